countdown_timer: RTL and testbench

Loadable down-counting timer with a valid/ready start interface and a valid/ready expiry event. Software-facing and pipeline-facing units use it for timeouts, watchdogs and periodic ticks. A start value V is accepted and counted down to expiry. Expiry is reported as a held event, with optional automatic reload for periodic operation and a sticky overrun flag for unacknowledged events.

---
 rtl/countdown_timer_pkg.sv | 8 +
 rtl/down_counter_load.sv | 39 +++
 rtl/countdown_timer.sv | 121 ++++++++++++
 tb/tb_countdown_timer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer.
package countdown_timer_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } timer_state_t;
endpackage

// File: rtl/down_counter_load.sv
// Loadable down counter with a registered "count equals one" flag.
module down_counter_load #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             is_one_o
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             is_one_q, is_one_d;

    // Load wins over decrement; the flag tracks the next count value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i)
            cnt_d = cnt_q - WIDTH'(1);
        is_one_d = (cnt_d == WIDTH'(1));
    end

    // Count and flag registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            is_one_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            is_one_q <= is_one_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign is_one_o = is_one_q;
endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with start handshake, held expiry event,
// optional periodic reload and sticky overrun flag.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int   WIDTH       = 16,
    parameter logic AUTO_RELOAD = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [WIDTH-1:0] start_value_i,
    input  logic             pause_i,
    input  logic             abort_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] count_o,
    output logic             busy_o,
    output logic             overrun_o
);
    timer_state_t     state_q, state_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             evt_q, evt_d;
    logic             ovr_q, ovr_d;
    logic             ld, dec, is_one;
    logic [WIDTH-1:0] ld_val;
    logic             ack;

    down_counter_load #(.WIDTH(WIDTH)) u_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ld),
        .load_val_i (ld_val),
        .dec_i      (dec),
        .cnt_o      (count_o),
        .is_one_o   (is_one)
    );

    assign ack = evt_q && evt_ready_i;

    // Next-state, counter control and event/overrun bookkeeping.
    always_comb begin
        state_d  = state_q;
        reload_d = reload_q;
        evt_d    = evt_q;
        ovr_d    = ovr_q;
        ld       = 1'b0;
        ld_val   = '0;
        dec      = 1'b0;
        if (ack)
            evt_d = 1'b0;
        if (abort_i) begin
            // Cancel drops everything, including any pending event.
            state_d = IDLE;
            ld      = 1'b1;
            evt_d   = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_valid_i) begin
                        if (start_value_i != '0) begin
                            ld       = 1'b1;
                            ld_val   = start_value_i;
                            reload_d = start_value_i;
                            ovr_d    = 1'b0;
                            state_d  = RUN;
                        end else begin
                            // Zero start expires at once, never periodic.
                            evt_d   = 1'b1;
                            state_d = DONE;
                        end
                    end
                end
                RUN: begin
                    if (!pause_i) begin
                        if (is_one) begin
                            // A still-unacked event is overwritten: flag it.
                            if (evt_q && !evt_ready_i)
                                ovr_d = 1'b1;
                            evt_d = 1'b1;
                            ld    = 1'b1;
                            if (AUTO_RELOAD)
                                ld_val = reload_q;
                            else
                                state_d = DONE;
                        end else begin
                            dec = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (ack)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, reload value, event and overrun registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            reload_q <= '0;
            evt_q    <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            reload_q <= reload_d;
            evt_q    <= evt_d;
            ovr_q    <= ovr_d;
        end
    end

    assign start_ready_o = (state_q == IDLE);
    assign busy_o        = (state_q == RUN);
    assign evt_valid_o   = evt_q;
    assign overrun_o     = ovr_q;
endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one-shot, periodic and narrow instances.
module tb_countdown_timer;
    logic        clk = 1'b0;
    logic        rst, sv_valid, pause, abort, ev_ready;
    logic [15:0] sv;
    int          checks = 0;
    int          errors = 0;

    logic        rdy1, evt1, busy1, ovr1;
    logic [15:0] cnt1;
    logic        rdy2, evt2, busy2, ovr2;
    logic [15:0] cnt2;
    logic        rdy3, evt3, busy3, ovr3;
    logic [7:0]  cnt3;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b0)) d1 (
        .clk_i(clk), .rst_i(rst), .start_valid_i(sv_valid), .start_ready_o(rdy1),
        .start_value_i(sv), .pause_i(pause), .abort_i(abort), .evt_valid_o(evt1),
        .evt_ready_i(ev_ready), .count_o(cnt1), .busy_o(busy1), .overrun_o(ovr1));

    countdown_timer #(.WIDTH(16), .AUTO_RELOAD(1'b1)) d2 (
        .clk_i(clk), .rst_i(rst), .start_valid_i(sv_valid), .start_ready_o(rdy2),
        .start_value_i(sv), .pause_i(pause), .abort_i(abort), .evt_valid_o(evt2),
        .evt_ready_i(ev_ready), .count_o(cnt2), .busy_o(busy2), .overrun_o(ovr2));

    countdown_timer #(.WIDTH(8), .AUTO_RELOAD(1'b0)) d3 (
        .clk_i(clk), .rst_i(rst), .start_valid_i(sv_valid), .start_ready_o(rdy3),
        .start_value_i(sv[7:0]), .pause_i(pause), .abort_i(abort), .evt_valid_o(evt3),
        .evt_ready_i(ev_ready), .count_o(cnt3), .busy_o(busy3), .overrun_o(ovr3));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sv_valid = 1'b0; sv = '0; pause = 1'b0; abort = 1'b0; ev_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic start(input logic [15:0] v);
        sv = v; sv_valid = 1'b1;
        tick();
        sv_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({rdy1, evt1, busy1, ovr1} !== 4'b1000) begin errors++; $display("FAIL reset_flags1 got %b exp 1000", {rdy1, evt1, busy1, ovr1}); end
        checks++; if (cnt1 !== 16'd0) begin errors++; $display("FAIL reset_cnt1 got %0d exp 0", cnt1); end
        checks++; if ({rdy2, evt2, busy2, ovr2, cnt2} !== {4'b1000, 16'd0}) begin errors++; $display("FAIL reset_d2 got %b/%0d exp 1000/0", {rdy2, evt2, busy2, ovr2}, cnt2); end
    endtask

    task automatic test_oneshot();
        do_reset();
        start(16'd5);
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL os_busy got %b exp 1", busy1); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (cnt1 !== 16'(5 - k) || evt1 !== 1'b0) begin errors++; $display("FAIL os_count k=%0d got %0d/%b exp %0d/0", k, cnt1, evt1, 5 - k); end
            tick();
        end
        checks++; if ({evt1, busy1, rdy1, cnt1} !== {3'b100, 16'd0}) begin errors++; $display("FAIL os_expiry got %b/%0d exp 100/0", {evt1, busy1, rdy1}, cnt1); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if ({evt1, rdy1} !== 2'b01) begin errors++; $display("FAIL os_ack got %b exp 01", {evt1, rdy1}); end
    endtask

    task automatic test_pause();
        do_reset();
        start(16'd4);
        tick();
        checks++; if (cnt1 !== 16'd3) begin errors++; $display("FAIL pause_pre got %0d exp 3", cnt1); end
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (cnt1 !== 16'd3 || busy1 !== 1'b1) begin errors++; $display("FAIL pause_hold k=%0d got %0d/%b exp 3/1", k, cnt1, busy1); end
        end
        pause = 1'b0;
        tick(); tick();
        checks++; if (cnt1 !== 16'd1 || evt1 !== 1'b0) begin errors++; $display("FAIL pause_late got %0d/%b exp 1/0", cnt1, evt1); end
        tick();
        checks++; if (evt1 !== 1'b1) begin errors++; $display("FAIL pause_evt got %b exp 1", evt1); end
    endtask

    task automatic test_periodic();
        do_reset();
        ev_ready = 1'b1;
        start(16'd3);
        for (int c = 1; c <= 10; c++) begin
            checks++; if (evt2 !== ((c >= 4) && ((c - 1) % 3 == 0)) || ovr2 !== 1'b0) begin errors++; $display("FAIL per_evt c=%0d got %b/%b exp %b/0", c, evt2, ovr2, (c >= 4) && ((c - 1) % 3 == 0)); end
            if (c == 10) ev_ready = 1'b0;
            tick();
        end
        checks++; if ({evt2, ovr2} !== 2'b10) begin errors++; $display("FAIL per_hold got %b exp 10", {evt2, ovr2}); end
        tick(); tick();
        checks++; if ({evt2, ovr2} !== 2'b11) begin errors++; $display("FAIL per_ovr got %b exp 11", {evt2, ovr2}); end
        tick(); tick(); tick();
        checks++; if ({evt2, ovr2, cnt2} !== {2'b11, 16'd3}) begin errors++; $display("FAIL per_ovr2 got %b/%0d exp 11/3", {evt2, ovr2}, cnt2); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if ({evt2, ovr2} !== 2'b01) begin errors++; $display("FAIL per_sticky got %b exp 01", {evt2, ovr2}); end
    endtask

    task automatic test_ack_coincide();
        do_reset();
        start(16'd2);
        tick(); tick(); tick();
        checks++; if ({evt2, cnt2} !== {1'b1, 16'd1}) begin errors++; $display("FAIL coin_pre got %b/%0d exp 1/1", evt2, cnt2); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if ({evt2, ovr2, cnt2} !== {2'b10, 16'd2}) begin errors++; $display("FAIL coin_same got %b/%0d exp 10/2", {evt2, ovr2}, cnt2); end
        tick();
        checks++; if ({evt2, ovr2} !== 2'b10) begin errors++; $display("FAIL coin_after got %b exp 10", {evt2, ovr2}); end
    endtask

    task automatic test_zero();
        do_reset();
        start(16'd0);
        checks++; if ({evt1, busy1, rdy1, cnt1} !== {3'b100, 16'd0}) begin errors++; $display("FAIL zero_os got %b/%0d exp 100/0", {evt1, busy1, rdy1}, cnt1); end
        tick(); tick();
        checks++; if ({evt2, busy2, rdy2, cnt2} !== {3'b100, 16'd0}) begin errors++; $display("FAIL zero_per got %b/%0d exp 100/0", {evt2, busy2, rdy2}, cnt2); end
        ev_ready = 1'b1;
        tick();
        ev_ready = 1'b0;
        checks++; if ({evt2, rdy2} !== 2'b01) begin errors++; $display("FAIL zero_ack got %b exp 01", {evt2, rdy2}); end
    endtask

    task automatic test_max();
        do_reset();
        start(16'h00FF);
        checks++; if (cnt3 !== 8'd255) begin errors++; $display("FAIL max_load got %0d exp 255", cnt3); end
        for (int c = 1; c < 255; c++) tick();
        checks++; if ({evt3, busy3, cnt3} !== {2'b01, 8'd1}) begin errors++; $display("FAIL max_one got %b/%0d exp 01/1", {evt3, busy3}, cnt3); end
        tick();
        checks++; if ({evt3, busy3, cnt3} !== {2'b10, 8'd0}) begin errors++; $display("FAIL max_evt got %b/%0d exp 10/0", {evt3, busy3}, cnt3); end
    endtask

    task automatic test_abort();
        do_reset();
        start(16'd2);
        for (int c = 1; c < 5; c++) tick();
        checks++; if ({evt2, ovr2, busy2} !== 3'b111) begin errors++; $display("FAIL abort_pre got %b exp 111", {evt2, ovr2, busy2}); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if ({rdy2, evt2, busy2, ovr2, cnt2} !== {4'b1000, 16'd0}) begin errors++; $display("FAIL abort_run got %b/%0d exp 1000/0", {rdy2, evt2, busy2, ovr2}, cnt2); end
        abort = 1'b1; sv = 16'd4; sv_valid = 1'b1;
        tick();
        abort = 1'b0; sv_valid = 1'b0;
        checks++; if ({rdy1, busy1, cnt1} !== {2'b10, 16'd0}) begin errors++; $display("FAIL abort_start got %b/%0d exp 10/0", {rdy1, busy1}, cnt1); end
        tick();
        checks++; if ({busy1, evt1} !== 2'b00) begin errors++; $display("FAIL abort_start2 got %b exp 00", {busy1, evt1}); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        start(16'd5);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({rdy1, evt1, busy1, ovr1, cnt1} !== {4'b1000, 16'd0}) begin errors++; $display("FAIL rst_mid got %b/%0d exp 1000/0", {rdy1, evt1, busy1, ovr1}, cnt1); end
        tick();
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_mid2 got %b exp 0", busy1); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_pause();
        test_periodic();
        test_ack_coincide();
        test_zero();
        test_max();
        test_abort();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
